// File: rtl/tug_playfield_n.sv
// Tug-of-war playfield: one light pushed left/right by button presses,
// round scoring, timed re-centre and match winner detection.
module tug_playfield_n #(
    parameter int N           = 9,
    parameter int HOLD_CYCLES = 4,
    parameter int WIN_ROUNDS  = 7,
    parameter int SCORE_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L,
    input  logic               R,
    output logic [N-1:0]       led,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               match_over
);

    localparam int PW = $clog2(N);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0]      CTR   = PW'((N - 1) / 2);
    localparam logic [PW-1:0]      LAST  = PW'(N - 1);
    localparam logic [HW-1:0]      HLAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_ROUNDS);

    if (WIN_ROUNDS < 1 || WIN_ROUNDS > (1 << SCORE_W) - 1) begin : g_bad_win
        $error("WIN_ROUNDS must be in 1..2^SCORE_W-1");
    end
    if (N < 3 || (N % 2) == 0) begin : g_bad_n
        $error("N must be odd and >= 3");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        PLAY,
        HOLD,
        OVER
    } state_t;

    state_t        st;
    logic [PW-1:0] pos;
    logic [HW-1:0] cnt;
    logic [1:0]    win_r;
    logic          L_q;
    logic          R_q;

    logic pl;
    logic pr;
    logic mv_l;
    logic mv_r;

    assign pl   = L & ~L_q;
    assign pr   = R & ~R_q;
    assign mv_l = pl & ~pr;
    assign mv_r = pr & ~pl;

    // Edge registers track the buttons unconditionally, so a button held
    // through reset or a HOLD/OVER period never counts as a new press.
    always_ff @(posedge clk) begin
        L_q <= L;
        R_q <= R;
        if (reset) begin
            st      <= PLAY;
            pos     <= CTR;
            cnt     <= '0;
            win_r   <= 2'b00;
            score_l <= '0;
            score_r <= '0;
        end else begin
            case (st)
                PLAY: begin
                    if (mv_l) begin
                        if (pos == LAST) begin
                            score_l <= score_l + 1'b1;
                            win_r   <= 2'b10;
                            cnt     <= '0;
                            st      <= HOLD;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end else if (mv_r) begin
                        if (pos == '0) begin
                            score_r <= score_r + 1'b1;
                            win_r   <= 2'b01;
                            cnt     <= '0;
                            st      <= HOLD;
                        end else begin
                            pos <= pos - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HLAST) begin
                        if ((win_r[1] ? score_l : score_r) == WIN) begin
                            st <= OVER;
                        end else begin
                            st    <= PLAY;
                            pos   <= CTR;
                            win_r <= 2'b00;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OVER: begin
                    st <= OVER;
                end
                default: begin
                    st <= PLAY;
                end
            endcase
        end
    end

    always_comb begin
        led = '0;
        if (st == PLAY) begin
            led = {{(N-1){1'b0}}, 1'b1} << pos;
        end
    end

    assign winner     = win_r;
    assign match_over = (st == OVER);

endmodule

// File: tb/tb_tug_playfield_n.sv
// Scoreboard bench for tug_playfield_n: three instances (N=9, N=5/WIN=2,
// N=3) driven by directed steps; a negedge monitor checks queued results.
module tb_tug_playfield_n;

    logic clk;
    logic reset;
    logic L;
    logic R;

    logic [8:0] led9;
    logic [1:0] w9;
    logic [2:0] sl9, sr9;
    logic       mo9;

    logic [4:0] led5;
    logic [1:0] w5;
    logic [2:0] sl5, sr5;
    logic       mo5;

    logic [2:0] led3;
    logic [1:0] w3;
    logic [2:0] sl3, sr3;
    logic       mo3;

    tug_playfield_n #(.N(9), .HOLD_CYCLES(4), .WIN_ROUNDS(7), .SCORE_W(3)) u9 (
        .clk(clk), .reset(reset), .L(L), .R(R),
        .led(led9), .winner(w9), .score_l(sl9), .score_r(sr9),
        .match_over(mo9)
    );

    tug_playfield_n #(.N(5), .HOLD_CYCLES(4), .WIN_ROUNDS(2), .SCORE_W(3)) u5 (
        .clk(clk), .reset(reset), .L(L), .R(R),
        .led(led5), .winner(w5), .score_l(sl5), .score_r(sr5),
        .match_over(mo5)
    );

    tug_playfield_n #(.N(3), .HOLD_CYCLES(4), .WIN_ROUNDS(7), .SCORE_W(3)) u3 (
        .clk(clk), .reset(reset), .L(L), .R(R),
        .led(led3), .winner(w3), .score_l(sl3), .score_r(sr3),
        .match_over(mo3)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] led;
        logic [1:0] w;
        logic [2:0] sl;
        logic [2:0] sr;
        logic       mo;
    } exp_t;

    exp_t       q[$];
    logic [1:0] sel;
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one DUT observation per cycle, compared against the queue.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a.id = e.id;
            case (e.id)
                2'd0:    begin a.led = led9; a.w = w9; a.sl = sl9; a.sr = sr9; a.mo = mo9; end
                2'd1:    begin a.led = {4'b0, led5}; a.w = w5; a.sl = sl5; a.sr = sr5; a.mo = mo5; end
                default: begin a.led = {6'b0, led3}; a.w = w3; a.sl = sl3; a.sr = sr3; a.mo = mo3; end
            endcase
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL chk%0d dut%0d got led=%b w=%b sl=%0d sr=%0d mo=%b want led=%b w=%b sl=%0d sr=%0d mo=%b",
                         checks, e.id, a.led, a.w, a.sl, a.sr, a.mo,
                         e.led, e.w, e.sl, e.sr, e.mo);
            end
        end
    end

    task automatic step(input logic rs, input logic l, input logic r,
                        input logic [8:0] el, input logic [1:0] ew,
                        input logic [2:0] esl, input logic [2:0] esr,
                        input logic emo);
        exp_t e;
        reset = rs;
        L     = l;
        R     = r;
        @(posedge clk);
        e.id  = sel;
        e.led = el;
        e.w   = ew;
        e.sl  = esl;
        e.sr  = esr;
        e.mo  = emo;
        q.push_back(e);
        @(negedge clk);
    endtask

    localparam logic [8:0] C9  = 9'b000010000;
    localparam logic [8:0] Z   = 9'b0;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] v;
        reset = 1'b1;
        L     = 1'b0;
        R     = 1'b0;
        sel   = 2'd0;
        @(negedge clk);

        // Reset state, then a held L moves once
        repeat (3) step(1, 0, 0, C9, 2'b00, 3'd0, 3'd0, 0);
        repeat (5) step(0, 1, 0, 9'b000100000, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 0, 9'b000100000, 2'b00, 3'd0, 3'd0, 0);

        // Alternating presses, simultaneous edges cancel
        step(0, 0, 1, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 0, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 1, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 0, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 0, 9'b000100000, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 1, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 1, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 0, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 1, 9'b000001000, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 1, C9, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 0, C9, 2'b00, 3'd0, 3'd0, 0);

        // Walk to the left edge, then win the round
        v = 9'b000100000;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, v, 2'b00, 3'd0, 3'd0, 0);
            step(0, 0, 0, v, 2'b00, 3'd0, 3'd0, 0);
            v = v << 1;
        end
        step(0, 1, 0, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 1, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 0, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 0, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 0, C9, 2'b00, 3'd1, 3'd0, 0);
        step(0, 0, 1, 9'b000001000, 2'b00, 3'd1, 3'd0, 0);
        step(0, 0, 0, 9'b000001000, 2'b00, 3'd1, 3'd0, 0);

        // N=5, WIN_ROUNDS=2: right takes the match
        sel = 2'd1;
        step(1, 0, 0, 9'b000000100, 2'b00, 3'd0, 3'd0, 0);
        for (int r = 1; r <= 2; r++) begin
            step(0, 0, 1, 9'b000000010, 2'b00, 3'd0, 3'(r - 1), 0);
            step(0, 0, 0, 9'b000000010, 2'b00, 3'd0, 3'(r - 1), 0);
            step(0, 0, 1, 9'b000000001, 2'b00, 3'd0, 3'(r - 1), 0);
            step(0, 0, 0, 9'b000000001, 2'b00, 3'd0, 3'(r - 1), 0);
            step(0, 0, 1, Z, 2'b01, 3'd0, 3'(r), 0);
            step(0, 0, 0, Z, 2'b01, 3'd0, 3'(r), 0);
            step(0, 1, 0, Z, 2'b01, 3'd0, 3'(r), 0);
            step(0, 0, 0, Z, 2'b01, 3'd0, 3'(r), 0);
            if (r == 1)
                step(0, 0, 0, 9'b000000100, 2'b00, 3'd0, 3'd1, 0);
            else
                step(0, 0, 0, Z, 2'b01, 3'd0, 3'd2, 1);
        end
        step(0, 1, 0, Z, 2'b01, 3'd0, 3'd2, 1);
        step(0, 0, 0, Z, 2'b01, 3'd0, 3'd2, 1);
        step(0, 0, 1, Z, 2'b01, 3'd0, 3'd2, 1);
        step(0, 0, 0, Z, 2'b01, 3'd0, 3'd2, 1);

        // N=3 boundaries, then reset in HOLD with L held
        sel = 2'd2;
        step(1, 0, 0, 9'b010, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 0, 9'b100, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 0, 9'b100, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 0, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 0, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 0, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 0, Z, 2'b10, 3'd1, 3'd0, 0);
        step(0, 0, 0, 9'b010, 2'b00, 3'd1, 3'd0, 0);
        step(0, 0, 1, 9'b001, 2'b00, 3'd1, 3'd0, 0);
        step(0, 0, 0, 9'b001, 2'b00, 3'd1, 3'd0, 0);
        step(0, 0, 1, Z, 2'b01, 3'd1, 3'd1, 0);
        step(0, 0, 0, Z, 2'b01, 3'd1, 3'd1, 0);
        step(0, 0, 0, Z, 2'b01, 3'd1, 3'd1, 0);
        step(0, 0, 0, Z, 2'b01, 3'd1, 3'd1, 0);
        step(0, 0, 0, 9'b010, 2'b00, 3'd1, 3'd1, 0);
        step(0, 1, 0, 9'b100, 2'b00, 3'd1, 3'd1, 0);
        step(0, 0, 0, 9'b100, 2'b00, 3'd1, 3'd1, 0);
        step(0, 1, 0, Z, 2'b10, 3'd2, 3'd1, 0);
        step(0, 0, 0, Z, 2'b10, 3'd2, 3'd1, 0);
        step(1, 1, 0, 9'b010, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 0, 9'b010, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 0, 9'b010, 2'b00, 3'd0, 3'd0, 0);
        step(0, 0, 0, 9'b010, 2'b00, 3'd0, 3'd0, 0);
        step(0, 1, 0, 9'b100, 2'b00, 3'd0, 3'd0, 0);

        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
